// File: rtl/ym_sr_slot_bank.sv
// Two-phase master/slave shift register bank holding one word per time slot,
// with recirculation, a mid-chain tap and a free-running slot counter.
module ym_sr_slot_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int SR_LENGTH  = 24,
    parameter int TAP        = 0,
    parameter int RECIRC     = 1,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  MCLK,
    input  logic                  reset,
    input  logic                  c1,
    input  logic                  c2,
    input  logic                  we,
    input  logic                  clear,
    input  logic                  sync,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] tap_out,
    output logic [CNT_WIDTH-1:0]  slot,
    output logic                  slot_last
);

    localparam logic [CNT_WIDTH-1:0] SLOT_LAST = CNT_WIDTH'(SR_LENGTH - 1);

    logic [SR_LENGTH-1:0][DATA_WIDTH-1:0] m_q, m_d;
    logic [SR_LENGTH-1:0][DATA_WIDTH-1:0] s_q, s_d;
    logic [CNT_WIDTH-1:0]                 slot_q, slot_d;

    // Both strobes on one edge act on old values, so c2 copies m_q, not m_d.
    always_comb begin
        m_d    = m_q;
        s_d    = s_q;
        slot_d = slot_q;
        if (c1) begin
            for (int k = 1; k < SR_LENGTH; k++) begin
                m_d[k] = s_q[k-1];
            end
            if (clear) begin
                m_d[0] = '0;
            end else if (we) begin
                m_d[0] = data_in;
            end else if (RECIRC != 0) begin
                m_d[0] = s_q[SR_LENGTH-1];
            end else begin
                m_d[0] = '0;
            end
            if (sync || (slot_q == SLOT_LAST)) begin
                slot_d = '0;
            end else begin
                slot_d = slot_q + 1'b1;
            end
        end
        if (c2) begin
            s_d = m_q;
        end
    end

    always_ff @(posedge MCLK or negedge reset) begin
        if (!reset) begin
            m_q    <= '0;
            s_q    <= '0;
            slot_q <= '0;
        end else begin
            m_q    <= m_d;
            s_q    <= s_d;
            slot_q <= slot_d;
        end
    end

    assign data_out  = s_q[SR_LENGTH-1];
    assign tap_out   = s_q[TAP];
    assign slot      = slot_q;
    assign slot_last = (slot_q == SLOT_LAST);

endmodule

// File: tb/tb_ym_sr_slot_bank.sv
// Directed bench for ym_sr_slot_bank: default instance plus a short
// non-recirculating 4x4 instance sharing the strobes.
module tb_ym_sr_slot_bank;

    logic       MCLK;
    logic       reset;
    logic       c1, c2, we, clear, sync;
    logic [7:0] data_in;
    logic [7:0] data_out, tap_out;
    logic [4:0] slot;
    logic       slot_last;

    logic       we2;
    logic [3:0] din2, dout2, tap2;
    logic [1:0] slot2;
    logic       slot_last2;

    int n_chk;
    int n_err;

    ym_sr_slot_bank dut (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .we(we), .clear(clear),
        .sync(sync), .data_in(data_in), .data_out(data_out), .tap_out(tap_out),
        .slot(slot), .slot_last(slot_last)
    );

    ym_sr_slot_bank #(.DATA_WIDTH(4), .SR_LENGTH(4), .TAP(0), .RECIRC(0), .CNT_WIDTH(2)) dut2 (
        .MCLK(MCLK), .reset(reset), .c1(c1), .c2(c2), .we(we2), .clear(clear),
        .sync(sync), .data_in(din2), .data_out(dout2), .tap_out(tap2),
        .slot(slot2), .slot_last(slot_last2)
    );

    initial begin
        MCLK = 1'b0;
        forever #5 MCLK = ~MCLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic c1_only(input logic w, input logic [7:0] d, input logic clr, input logic syn);
        @(negedge MCLK);
        we = w; data_in = d; clear = clr; sync = syn; c1 = 1'b1;
        @(negedge MCLK);
        c1 = 1'b0; we = 1'b0; clear = 1'b0; sync = 1'b0;
    endtask

    task automatic c2_only();
        @(negedge MCLK);
        c2 = 1'b1;
        @(negedge MCLK);
        c2 = 1'b0;
    endtask

    task automatic step(input logic w, input logic [7:0] d, input logic clr, input logic syn);
        c1_only(w, d, clr, syn);
        c2_only();
    endtask

    task automatic do_reset();
        @(negedge MCLK);
        reset = 1'b0;
        @(negedge MCLK);
        reset = 1'b1;
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        reset = 1'b0; c1 = 0; c2 = 0; we = 0; clear = 0; sync = 0; data_in = '0;
        we2 = 0; din2 = '0;

        // reset held with random strobes
        for (int i = 0; i < 8; i++) begin
            @(negedge MCLK);
            c1 = 1'($urandom_range(0, 1));
            c2 = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            data_in = 8'($urandom_range(0, 255));
        end
        @(negedge MCLK);
        c1 = 0; c2 = 0; we = 0;
        chk("rst_data_out", 32'(data_out), 0);
        chk("rst_tap_out", 32'(tap_out), 0);
        chk("rst_slot", 32'(slot), 0);
        chk("rst_slot_last", 32'(slot_last), 0);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) step(0, 8'h00, 0, 0);
        chk("idle_data_out", 32'(data_out), 0);
        chk("idle_tap_out", 32'(tap_out), 0);
        chk("idle_slot", 32'(slot), 10);

        // write latency and slot wrap
        do_reset();
        for (int k = 0; k <= 24; k++) begin
            chk($sformatf("lat_slot_%0d", k), 32'(slot), 32'(k % 24));
            chk($sformatf("lat_last_%0d", k), 32'(slot_last), (k == 23) ? 1 : 0);
            step(k == 0, 8'hA5, 0, 0);
            if (k == 0) chk("lat_tap", 32'(tap_out), 32'hA5);
            chk($sformatf("lat_dout_%0d", k), 32'(data_out), (k == 23) ? 32'hA5 : 0);
        end

        // recirculation across 3 revolutions, then clear overriding we
        do_reset();
        for (int k = 0; k <= 124; k++) begin
            if (k == 5 || k == 77) chk($sformatf("rc_slot_%0d", k), 32'(slot), 5);
            if (k == 77) step(1, 8'hFF, 1, 0);
            else step(k == 5, 8'h3C, 0, 0);
            chk($sformatf("rc_dout_%0d", k), 32'(data_out),
                (k == 28 || k == 52 || k == 76) ? 32'h3C : 0);
        end

        // non-recirculating short bank
        do_reset();
        for (int k = 0; k < 12; k++) begin
            we2 = (k == 0); din2 = 4'h9;
            step(0, 8'h00, 0, 0);
            we2 = 0;
            chk($sformatf("nr_dout_%0d", k), 32'(dout2), (k == 3) ? 32'h9 : 0);
        end

        // sync realignment
        do_reset();
        for (int k = 0; k < 7; k++) step(0, 8'h00, 0, 0);
        chk("sync_pre_slot", 32'(slot), 7);
        c1_only(0, 8'h00, 0, 1);
        chk("sync_slot_after_c1", 32'(slot), 0);
        c2_only();
        for (int k = 0; k < 23; k++) step(0, 8'h00, 0, 0);
        chk("sync_last", 32'(slot_last), 1);
        step(0, 8'h00, 0, 0);
        chk("sync_wrap", 32'(slot), 0);

        // simultaneous strobes
        do_reset();
        step(1, 8'h11, 0, 0);
        c1_only(1, 8'h22, 0, 0);
        chk("both_pre_tap", 32'(tap_out), 32'h11);
        @(negedge MCLK);
        we = 1; data_in = 8'h33; c1 = 1; c2 = 1;
        @(negedge MCLK);
        we = 0; c1 = 0; c2 = 0;
        chk("both_tap", 32'(tap_out), 32'h22);
        chk("both_slot", 32'(slot), 3);
        c2_only();
        chk("both_tap_after_c2", 32'(tap_out), 32'h33);
        chk("both_dout", 32'(data_out), 0);

        // reset between c1 and c2
        do_reset();
        for (int k = 0; k < 4; k++) step(1, 8'hAA, 0, 0);
        chk("mid_pre_tap", 32'(tap_out), 32'hAA);
        c1_only(1, 8'hAA, 0, 0);
        chk("mid_pre_slot", 32'(slot), 5);
        #2 reset = 1'b0;
        #1;
        chk("mid_tap_async", 32'(tap_out), 0);
        chk("mid_slot_async", 32'(slot), 0);
        chk("mid_dout_async", 32'(data_out), 0);
        @(negedge MCLK);
        reset = 1'b1;
        c2_only();
        chk("mid_tap_after_c2", 32'(tap_out), 0);
        chk("mid_dout_after_c2", 32'(data_out), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
